// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// alu_core : registered add/subtract with zero/sign (and optional overflow)
//            flags; ALU_OVERFLOW_FLAG_EN adds the overflow_out port. Rev 1.0
// ============================================================================
module alu_core #(
   parameter int DATA_WIDTH = 11
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic [DATA_WIDTH-1:0] A_in,
   input  logic [DATA_WIDTH-1:0] B_in,
   input  logic                  operation,
   output logic [DATA_WIDTH-1:0] alu_out,
   output logic                  zero_indicator_out,
   output logic                  signal_bit_out
`ifdef ALU_OVERFLOW_FLAG_EN
   ,
   output logic                  overflow_out
`endif
);

   localparam int MSB = DATA_WIDTH - 1;

   logic [DATA_WIDTH-1:0] b_eff;
   logic [DATA_WIDTH-1:0] carry_in;
   logic [DATA_WIDTH-1:0] sum;

   // Subtract reuses the adder as A + ~B + 1; the carry out is dropped.
   always_comb begin
      b_eff    = operation ? ~B_in : B_in;
      carry_in = {{(DATA_WIDTH-1){1'b0}}, operation};
      sum      = A_in + b_eff + carry_in;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         alu_out            <= '0;
         zero_indicator_out <= 1'b1;
         signal_bit_out     <= 1'b0;
      end else begin
         alu_out            <= sum;
         zero_indicator_out <= (sum == '0);
         signal_bit_out     <= sum[MSB];
      end
   end

`ifdef ALU_OVERFLOW_FLAG_EN
   // Same-sign adder inputs producing a differently-signed sum covers both ops.
   logic ovf;

   always_comb begin
      ovf = (A_in[MSB] == b_eff[MSB]) && (sum[MSB] != A_in[MSB]);
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         overflow_out <= 1'b0;
      end else begin
         overflow_out <= ovf;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_core.sv
`default_nettype none
// ============================================================================
// tb_alu_core : scoreboard bench for alu_core with directed vectors. Rev 1.0
// ============================================================================
module tb_alu_core;

   localparam int DW = 11;

   logic          clk_in;
   logic          rst_n_in;
   logic [DW-1:0] A_in;
   logic [DW-1:0] B_in;
   logic          operation;
   logic [DW-1:0] alu_out;
   logic          zero_indicator_out;
   logic          signal_bit_out;
`ifdef ALU_OVERFLOW_FLAG_EN
   logic          overflow_out;
`endif

   alu_core #(.DATA_WIDTH(DW)) dut (
      .clk_in             (clk_in),
      .rst_n_in           (rst_n_in),
      .A_in               (A_in),
      .B_in               (B_in),
      .operation          (operation),
      .alu_out            (alu_out),
      .zero_indicator_out (zero_indicator_out),
      .signal_bit_out     (signal_bit_out)
`ifdef ALU_OVERFLOW_FLAG_EN
      ,
      .overflow_out       (overflow_out)
`endif
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      int            id;
      logic [DW-1:0] res;
      logic          z;
      logic          s;
      logic          o;
   } exp_t;

   exp_t expq[$];
   int   tests_run;
   int   tests_failed;

   task automatic check(input string name, input int id, input logic [31:0] act,
                        input logic [31:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("FAIL %s vec%0d: got 0x%0h expected 0x%0h", name, id, act, req);
      end
   endtask

   // Monitor: outputs are valid every cycle, compared #1 after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_in);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            check("alu_out", e.id, {21'd0, alu_out}, {21'd0, e.res});
            check("zero", e.id, {31'd0, zero_indicator_out}, {31'd0, e.z});
            check("sign", e.id, {31'd0, signal_bit_out}, {31'd0, e.s});
`ifdef ALU_OVERFLOW_FLAG_EN
            check("overflow", e.id, {31'd0, overflow_out}, {31'd0, e.o});
`endif
         end
      end
   end

   int vec_id;

   task automatic step(input logic rst_n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic op, input logic [DW-1:0] er, input logic ez,
                       input logic es, input logic eo);
      exp_t e;
      @(negedge clk_in);
      rst_n_in  = rst_n;
      A_in      = a;
      B_in      = b;
      operation = op;
      e.id  = vec_id;
      e.res = er;
      e.z   = ez;
      e.s   = es;
      e.o   = eo;
      expq.push_back(e);
      vec_id++;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      vec_id       = 0;
      rst_n_in     = 1'b0;
      A_in         = '0;
      B_in         = '0;
      operation    = 1'b0;

      //     rst   A        B        op    result   z     s     ovf
      step(1'b0, 11'h3FF, 11'h001, 1'b0, 11'h000, 1'b1, 1'b0, 1'b0);
      step(1'b0, 11'h3FF, 11'h001, 1'b0, 11'h000, 1'b1, 1'b0, 1'b0);
      step(1'b1, 11'h3FF, 11'h001, 1'b0, 11'h400, 1'b0, 1'b1, 1'b1);
      step(1'b1, 11'h3FF, 11'h001, 1'b1, 11'h3FE, 1'b0, 1'b0, 1'b0);
      step(1'b1, 11'h3FF, 11'h002, 1'b1, 11'h3FD, 1'b0, 1'b0, 1'b0);
      step(1'b1, 11'h3FF, 11'h002, 1'b0, 11'h401, 1'b0, 1'b1, 1'b1);
      step(1'b1, 11'h003, 11'h002, 1'b0, 11'h005, 1'b0, 1'b0, 1'b0);
      step(1'b1, 11'h003, 11'h002, 1'b1, 11'h001, 1'b0, 1'b0, 1'b0);
      step(1'b1, 11'h005, 11'h005, 1'b1, 11'h000, 1'b1, 1'b0, 1'b0);
      step(1'b1, 11'h000, 11'h001, 1'b1, 11'h7FF, 1'b0, 1'b1, 1'b0);
      step(1'b1, 11'h400, 11'h001, 1'b1, 11'h3FF, 1'b0, 1'b0, 1'b1);
      step(1'b1, 11'h400, 11'h400, 1'b0, 11'h000, 1'b1, 1'b0, 1'b1);
      step(1'b1, 11'h7FF, 11'h7FF, 1'b0, 11'h7FE, 1'b0, 1'b1, 1'b0);
      step(1'b1, 11'h400, 11'h7FF, 1'b1, 11'h401, 1'b0, 1'b1, 1'b0);
      // Reset arrives with the op change; result shows only after release.
      step(1'b1, 11'h3FF, 11'h001, 1'b0, 11'h400, 1'b0, 1'b1, 1'b1);
      step(1'b0, 11'h3FF, 11'h001, 1'b1, 11'h000, 1'b1, 1'b0, 1'b0);
      step(1'b1, 11'h3FF, 11'h001, 1'b1, 11'h3FE, 1'b0, 1'b0, 1'b0);
      step(1'b1, 11'h001, 11'h7FF, 1'b0, 11'h000, 1'b1, 1'b0, 1'b0);

      for (int i = 0; i < 20 && expq.size() > 0; i++) @(posedge clk_in);
      #2;
      tests_run++;
      if (expq.size() != 0) begin
         tests_failed++;
         $display("FAIL drain: got %0d pending expected 0 pending", expq.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
